dds_voice_scheduler: RTL and testbench
======================================

// Module: dds_voice_scheduler
// PURPOSE
//  Control block for the DDS phase-accumulator datapath. Per audio sample tick it steps the DDS
//  pipeline (read/compute/update) through every voice in turn. It also turns MIDI note-on/off
//  requests into voice assignments. Assignments reach the DDS as paced single-cycle update pulses,
//  so no update is lost while the DDS still holds a buffered one. It sits between the MIDI/SPI
//  front end and the DDS, and provides the voice-gate mask for the mixer.
// PARAMETERS
//  NUM_VOICES  8  voices sequenced and allocated, 1..256
//  VOICE_W     8  width of a voice index
//  NOTE_W      7  width of a MIDI note number
// PORTS
//  i_clk             in   1        system clock, all logic on rising edge
//  i_reset_n         in   1        reset, asynchronous, active-low
//  i_sample_tick     in   1        1-cycle strobe: start one frame (all voices)
//  i_note_valid      in   1        note request valid
//  i_note_on         in   1        1 = note-on, 0 = note-off
//  i_note            in   NOTE_W   MIDI note number
//  o_note_ready      out  1        allocator idle; request accepted when valid&ready
//  o_pipeline_state  out  2        DDS pipeline state: 0 read, 1 compute, 2 update, 3 idle
//  o_voice_index     out  VOICE_W  voice the DDS is to process
//  o_upd_flag        out  1        1-cycle pulse: load new tuning for o_upd_voice
//  o_upd_note        out  NOTE_W   note for the update; held stable until next pulse
//  o_upd_voice       out  VOICE_W  target voice for the update; held stable
//  o_gate            out  NUM_VOICES  per-voice active mask (to mixer)
//  o_frame_done      out  1        1-cycle pulse after last voice's state 2
//  o_overrun         out  1        sticky: a tick arrived while a frame was running
// BEHAVIOUR
//  Reset (async assert, sync release): o_pipeline_state=3, o_voice_index=0, o_upd_flag=0,
//   o_upd_note=0, o_upd_voice=0, o_gate=0, o_frame_done=0, o_overrun=0, o_note_ready=1;
//   voice table cleared and the round-robin pointer set to 0.
//   Reset mid-frame or mid-search abandons it. No pulse is emitted.
//  Frame sequencer:
//   - Tick in idle (state 3) at cycle t: cycle t+1 drives state 0, voice 0.
//   - Sequence per voice is 0,1,2, one cycle each, voices 0..NUM_VOICES-1, 3*NUM_VOICES cycles.
//   - The cycle after the last state 2 returns to 3 with o_frame_done=1.
//   - A tick in any state other than 3 is dropped and sets o_overrun; only reset clears it.
//   - A tick coincident with o_frame_done is also an overrun.
//  Allocator FSM (IDLE -> SEARCH -> ISSUE -> WAIT -> IDLE):
//   - IDLE: ready=1. On valid&ready it latches on/note and goes to SEARCH with ready=0.
//   - SEARCH scans one table entry per cycle, index 0..NUM_VOICES-1, so NUM_VOICES cycles.
//     It records the first active entry whose note matches, and the first inactive entry.
//   - Note-on: if a matching active voice exists, retrigger it. Otherwise use the lowest free
//     voice. If none is free, steal the voice at the RR pointer and advance the pointer mod
//     NUM_VOICES. Write table {active=1,note} and set gate. Go to ISSUE.
//   - Note-off: a match clears active and the gate. It needs no DDS update, so go to IDLE.
//     No match is a no-op; go to IDLE.
//   - ISSUE drives o_upd_flag=1 for one cycle with o_upd_note/o_upd_voice, then goes to WAIT.
//   - WAIT holds until one o_pipeline_state==2 cycle has occurred after the ISSUE cycle, then
//     one further cycle, then goes to IDLE. This matches the DDS one-deep update buffer.
//   - The DDS drains its buffer only during state 2, so an idle sequencer stalls WAIT until
//     the next frame.
//  Table writes from SEARCH completion are visible to the next request; there is no bypass.
//  All index arithmetic wraps modulo NUM_VOICES. Note values are passed through unmodified.
// STRUCTURE
//  Shared package dds_pkg:
//   - PS_READ=0, PS_COMPUTE=1, PS_UPDATE=2, PS_IDLE=3
//   - allocator state encoding AL_IDLE/AL_SEARCH/AL_ISSUE/AL_WAIT
//   - default voice count and width constants
//  Sub-module voice_allocator holds the table, RR pointer and allocator FSM. It takes
//  o_pipeline_state as input for WAIT release. The top level holds the frame sequencer.
// TESTING
//  1 Reset, tick at t=10, NUM_VOICES=8 -> states 0,1,2 per voice 0..7 at t=11..34;
//    o_frame_done at t=35; state 3 after.
//  2 Tick at frame cycle 5 -> ignored, frame still ends at 3*8 cycles, o_overrun=1
//    until reset.
//  3 Note-on 60 then note-on 64 -> pulses with voice 0 note 60, then voice 1 note 64;
//    o_gate=8'b0000_0011. The second pulse only follows a state-2 cycle plus 1.
//  4 Eight note-ons 60..67, then note-on 70 -> voice 0 is stolen (pulse voice0/note70),
//    RR=1; note-on 71 steals voice 1.
//  5 Note-on 60 (voice 0), note-on 60 again -> retrigger pulse voice 0. Note-off 60 ->
//    o_gate[0]=0, no pulse. Note-off 61 -> no change.
//  6 Assert i_reset_n=0 during SEARCH and mid-frame -> outputs immediately at reset
//    values, no o_upd_flag; a fresh request after release allocates voice 0.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS voice scheduler: pipeline and allocator state
// encodings plus default sizing constants.
package dds_pkg;

  localparam int DEF_NUM_VOICES = 8;
  localparam int DEF_VOICE_W    = 8;
  localparam int DEF_NOTE_W     = 7;

  // DDS pipeline step presented to the datapath; values are visible on a port.
  typedef enum logic [1:0] {
    PS_READ    = 2'd0,
    PS_COMPUTE = 2'd1,
    PS_UPDATE  = 2'd2,
    PS_IDLE    = 2'd3
  } ps_e;

  // Voice allocator control states.
  typedef enum logic [1:0] {
    AL_IDLE   = 2'd0,
    AL_SEARCH = 2'd1,
    AL_ISSUE  = 2'd2,
    AL_WAIT   = 2'd3
  } al_state_e;

endpackage

// File: rtl/dds_voice_scheduler_voice_allocator.sv
// Voice allocator: owns the voice table and round-robin steal pointer, turns
// note-on/off requests into table updates, and paces DDS tuning updates so the
// DDS one-deep update buffer is drained before the next one is issued.
module voice_allocator
  import dds_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int VOICE_W    = DEF_VOICE_W,
  parameter int NOTE_W     = DEF_NOTE_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_note_valid,
  input  logic                  i_note_on,
  input  logic [NOTE_W-1:0]     i_note,
  input  logic [1:0]            i_pipeline_state,
  output logic                  o_note_ready,
  output logic                  o_upd_flag,
  output logic [NOTE_W-1:0]     o_upd_note,
  output logic [VOICE_W-1:0]    o_upd_voice,
  output logic [NUM_VOICES-1:0] o_gate
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  al_state_e                 state_q, state_d;
  logic                      req_on_q, req_on_d;
  logic [NOTE_W-1:0]         req_note_q, req_note_d;
  logic [IDX_W-1:0]          scan_q, scan_d;
  logic                      match_found_q, match_found_d;
  logic [IDX_W-1:0]          match_idx_q, match_idx_d;
  logic                      free_found_q, free_found_d;
  logic [IDX_W-1:0]          free_idx_q, free_idx_d;
  logic [IDX_W-1:0]          rr_q, rr_d;
  logic [NUM_VOICES-1:0]     active_q, active_d;
  logic [NOTE_W-1:0]         note_tab_q [NUM_VOICES];
  logic [NOTE_W-1:0]         note_tab_d [NUM_VOICES];
  logic [NOTE_W-1:0]         upd_note_q, upd_note_d;
  logic [VOICE_W-1:0]        upd_voice_q, upd_voice_d;
  logic                      seen_q, seen_d;

  // Search results including the entry examined this cycle.
  logic                      eff_match_found, eff_free_found;
  logic [IDX_W-1:0]          eff_match_idx, eff_free_idx;
  logic [IDX_W-1:0]          target;

  // Allocator next-state: scan the table, pick a voice, update the table, pace the pulse.
  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d       = state_q;
    req_on_d      = req_on_q;
    req_note_d    = req_note_q;
    scan_d        = scan_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    rr_d          = rr_q;
    active_d      = active_q;
    note_tab_d    = note_tab_q;
    upd_note_d    = upd_note_q;
    upd_voice_d   = upd_voice_q;
    seen_d        = seen_q;
    target        = '0;

    eff_match_found = match_found_q ||
                      (active_q[scan_q] && (note_tab_q[scan_q] == req_note_q));
    eff_match_idx   = match_found_q ? match_idx_q : scan_q;
    eff_free_found  = free_found_q || !active_q[scan_q];
    eff_free_idx    = free_found_q ? free_idx_q : scan_q;

    case (state_q)
      AL_IDLE: begin
        if (i_note_valid) begin
          req_on_d      = i_note_on;
          req_note_d    = i_note;
          scan_d        = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          state_d       = AL_SEARCH;
        end
      end
      AL_SEARCH: begin
        match_found_d = eff_match_found;
        match_idx_d   = eff_match_idx;
        free_found_d  = eff_free_found;
        free_idx_d    = eff_free_idx;
        scan_d        = scan_q + 1'b1;
        if (scan_q == LAST_IDX) begin
          if (req_on_q) begin
            // Retrigger beats a free voice; stealing is the last resort.
            if (eff_match_found) begin
              target = eff_match_idx;
            end else if (eff_free_found) begin
              target = eff_free_idx;
            end else begin
              target = rr_q;
              rr_d   = (rr_q == LAST_IDX) ? '0 : rr_q + 1'b1;
            end
            active_d[target]   = 1'b1;
            note_tab_d[target] = req_note_q;
            upd_note_d         = req_note_q;
            upd_voice_d        = VOICE_W'(target);
            state_d            = AL_ISSUE;
          end else begin
            // A release needs no DDS retune; an unmatched release does nothing.
            if (eff_match_found) begin
              active_d[eff_match_idx] = 1'b0;
            end
            state_d = AL_IDLE;
          end
        end
      end
      AL_ISSUE: begin
        seen_d  = 1'b0;
        state_d = AL_WAIT;
      end
      AL_WAIT: begin
        // The DDS drains its buffered update during a state-2 cycle; allow one more
        // cycle after that before another update may be issued.
        if (seen_q) begin
          state_d = AL_IDLE;
        end else if (i_pipeline_state == PS_UPDATE) begin
          seen_d = 1'b1;
        end
      end
      default: state_d = AL_IDLE;
    endcase
  end

  // Allocator registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= AL_IDLE;
      req_on_q      <= 1'b0;
      req_note_q    <= '0;
      scan_q        <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      rr_q          <= '0;
      active_q      <= '0;
      // NOTE: the note table is cleared with the rest of the voice table so the
      // post-reset contents are fully defined, not just the active bits.
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_tab_q[i] <= '0;
      end
      upd_note_q    <= '0;
      upd_voice_q   <= '0;
      seen_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q       <= state_d;
      req_on_q      <= req_on_d;
      req_note_q    <= req_note_d;
      scan_q        <= scan_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      rr_q          <= rr_d;
      active_q      <= active_d;
      note_tab_q    <= note_tab_d;
      upd_note_q    <= upd_note_d;
      upd_voice_q   <= upd_voice_d;
      seen_q        <= seen_d;
    end
  end

  assign o_note_ready = (state_q == AL_IDLE);
  assign o_upd_flag   = (state_q == AL_ISSUE);
  assign o_upd_note   = upd_note_q;
  assign o_upd_voice  = upd_voice_q;
  assign o_gate       = active_q;

endmodule

// File: rtl/dds_voice_scheduler.sv
// DDS voice scheduler top: per sample tick, steps the DDS pipeline through
// read/compute/update for every voice, flags overlapping ticks, and hosts the
// voice allocator that feeds tuning updates and the mixer gate mask.
module dds_voice_scheduler
  import dds_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int VOICE_W    = DEF_VOICE_W,
  parameter int NOTE_W     = DEF_NOTE_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_sample_tick,
  input  logic                  i_note_valid,
  input  logic                  i_note_on,
  input  logic [NOTE_W-1:0]     i_note,
  output logic                  o_note_ready,
  output logic [1:0]            o_pipeline_state,
  output logic [VOICE_W-1:0]    o_voice_index,
  output logic                  o_upd_flag,
  output logic [NOTE_W-1:0]     o_upd_note,
  output logic [VOICE_W-1:0]    o_upd_voice,
  output logic [NUM_VOICES-1:0] o_gate,
  output logic                  o_frame_done,
  output logic                  o_overrun
);

  localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);

  ps_e                ps_q, ps_d;
  logic [VOICE_W-1:0] voice_q, voice_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;

  // Frame sequencer: 0,1,2 per voice for all voices, then back to idle with a done pulse.
  always_comb begin
    ps_d         = ps_q;
    voice_d      = voice_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    // The done cycle still belongs to the previous frame, so a tick there is dropped too.
    if (i_sample_tick && ((ps_q != PS_IDLE) || frame_done_q)) begin
      overrun_d = 1'b1;
    end

    case (ps_q)
      PS_IDLE: begin
        if (i_sample_tick && !frame_done_q) begin
          ps_d    = PS_READ;
          voice_d = '0;
        end
      end
      PS_READ:    ps_d = PS_COMPUTE;
      PS_COMPUTE: ps_d = PS_UPDATE;
      PS_UPDATE: begin
        if (voice_q == LAST_VOICE) begin
          ps_d         = PS_IDLE;
          voice_d      = '0;
          frame_done_d = 1'b1;
        end else begin
          ps_d    = PS_READ;
          voice_d = voice_q + 1'b1;
        end
      end
      default: ps_d = PS_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ps_q         <= PS_IDLE;
      voice_q      <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      ps_q         <= ps_d;
      voice_q      <= voice_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_pipeline_state = ps_q;
  assign o_voice_index    = voice_q;
  assign o_frame_done     = frame_done_q;
  assign o_overrun        = overrun_q;

  voice_allocator #(
    .NUM_VOICES (NUM_VOICES),
    .VOICE_W    (VOICE_W),
    .NOTE_W     (NOTE_W)
  ) u_alloc (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_note_valid     (i_note_valid),
    .i_note_on        (i_note_on),
    .i_note           (i_note),
    .i_pipeline_state (o_pipeline_state),
    .o_note_ready     (o_note_ready),
    .o_upd_flag       (o_upd_flag),
    .o_upd_note       (o_upd_note),
    .o_upd_voice      (o_upd_voice),
    .o_gate           (o_gate)
  );

endmodule

// File: tb/tb_dds_voice_scheduler.sv
// Self-checking bench for dds_voice_scheduler: directed scenarios plus randomized
// note traffic and sample ticks, checked against a behavioural frame/voice model.
module tb_dds_voice_scheduler;

  localparam int N  = 8;
  localparam int VW = 8;
  localparam int NW = 7;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b1;
  logic          i_sample_tick = 1'b0;
  logic          i_note_valid = 1'b0;
  logic          i_note_on = 1'b0;
  logic [NW-1:0] i_note = '0;
  logic          o_note_ready;
  logic [1:0]    o_pipeline_state;
  logic [VW-1:0] o_voice_index;
  logic          o_upd_flag;
  logic [NW-1:0] o_upd_note;
  logic [VW-1:0] o_upd_voice;
  logic [N-1:0]  o_gate;
  logic          o_frame_done;
  logic          o_overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  dds_voice_scheduler #(.NUM_VOICES(N), .VOICE_W(VW), .NOTE_W(NW)) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_sample_tick    (i_sample_tick),
    .i_note_valid     (i_note_valid),
    .i_note_on        (i_note_on),
    .i_note           (i_note),
    .o_note_ready     (o_note_ready),
    .o_pipeline_state (o_pipeline_state),
    .o_voice_index    (o_voice_index),
    .o_upd_flag       (o_upd_flag),
    .o_upd_note       (o_upd_note),
    .o_upd_voice      (o_upd_voice),
    .o_gate           (o_gate),
    .o_frame_done     (o_frame_done),
    .o_overrun        (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- frame model: a frame is a window of 3*N cycles after an accepted tick
  int cyc = 0;            // posedges seen; after edge e the visible index is e
  int frame_start = -1000;
  bit exp_overrun = 1'b0;

  function automatic bit frame_busy(input int d);
    int p;
    p = d - frame_start;
    return (p >= 0) && (p <= 3 * N);
  endfunction

  function automatic int exp_ps();
    int p;
    p = (cyc - 1) - frame_start;
    if (p >= 0 && p < 3 * N) return p % 3;
    return 3;
  endfunction

  always @(posedge i_clk) begin
    if (!i_reset_n) begin
      frame_start <= -1000;
      exp_overrun <= 1'b0;
    end else if (i_sample_tick) begin
      if (frame_busy(cyc - 1)) exp_overrun <= 1'b1;
      else                     frame_start <= cyc;
    end
    cyc <= cyc + 1;
  end

  bit mon_en = 1'b0;
  int mon_p;
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (!i_reset_n) begin
        check("rst_ps", o_pipeline_state, 3);
        check("rst_done", o_frame_done, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_flag", o_upd_flag, 0);
      end else begin
        mon_p = (cyc - 1) - frame_start;
        if (mon_p >= 0 && mon_p < 3 * N) begin
          check("mon_ps", o_pipeline_state, mon_p % 3);
          check("mon_voice", o_voice_index, mon_p / 3);
          check("mon_done", o_frame_done, 0);
        end else begin
          check("mon_ps_idle", o_pipeline_state, 3);
          check("mon_done_idle", o_frame_done, (mon_p == 3 * N));
        end
        check("mon_overrun", o_overrun, exp_overrun);
      end
    end
  end

  // ---------------- voice table model
  bit m_active [N];
  int m_note   [N];
  int m_rr;
  int last_note, last_voice;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0;
      m_note[i]   = 0;
    end
    m_rr = 0;
    last_note = 0;
    last_voice = 0;
  endtask

  function automatic logic [N-1:0] model_gate();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = m_active[i];
    return g;
  endfunction

  task automatic model_alloc(input bit on, input int note, output bit issue, output int voice);
    int hit, free;
    hit = -1;
    free = -1;
    for (int i = 0; i < N; i++) begin
      if (m_active[i] && m_note[i] == note && hit < 0) hit = i;
      if (!m_active[i] && free < 0) free = i;
    end
    issue = on;
    voice = 0;
    if (on) begin
      if (hit >= 0)       voice = hit;
      else if (free >= 0) voice = free;
      else begin
        voice = m_rr;
        m_rr = (m_rr + 1) % N;
      end
      m_active[voice] = 1'b1;
      m_note[voice]   = note;
    end else if (hit >= 0) begin
      m_active[hit] = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers (all driving happens at negedges)
  bit auto_tick  = 1'b0;
  bit force_tick = 1'b0;

  task automatic step();
    @(negedge i_clk);
    i_sample_tick = force_tick || (auto_tick && ($urandom_range(0, 11) == 0));
    force_tick = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    i_reset_n = 1'b0;
    i_note_valid = 1'b0;
    i_sample_tick = 1'b0;
    force_tick = 1'b0;
    model_reset();
    step();
    step();
    i_reset_n = 1'b1;
    step();
  endtask

  task automatic note_req(input bit on, input int note);
    bit issue;
    int voice;
    int n;
    n = 0;
    while (o_note_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("req_ready", o_note_ready, 1);
    i_note_valid = 1'b1;
    i_note_on = on;
    i_note = NW'(note);
    model_alloc(on, note, issue, voice);
    step();
    i_note_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      check("search_ready", o_note_ready, 0);
      check("search_flag", o_upd_flag, 0);
      step();
    end
    check("issue_flag", o_upd_flag, issue);
    check("gate_after_search", o_gate, model_gate());
    if (issue) begin
      check("issue_note", o_upd_note, note);
      check("issue_voice", o_upd_voice, voice);
      check("issue_ready", o_note_ready, 0);
      last_note = note;
      last_voice = voice;
      n = 0;
      do begin
        if (n == 20) force_tick = 1'b1;
        step();
        n++;
        check("wait_ready", o_note_ready, 0);
        check("wait_flag", o_upd_flag, 0);
      end while (exp_ps() != 2 && n < 300);
      check("wait_update_cycle", o_pipeline_state, 2);
      step();
      check("wait_tail_ready", o_note_ready, 0);
      step();
      check("wait_release_ready", o_note_ready, 1);
    end else begin
      check("off_ready", o_note_ready, 1);
    end
    check("hold_note", o_upd_note, last_note);
    check("hold_voice", o_upd_voice, last_voice);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    model_reset();
    #1;
    do_reset();
    mon_en = 1'b1;

    // 1: reset values, then a full frame from a single tick
    repeat (9) step();
    check("reset_ps", o_pipeline_state, 3);
    check("reset_voice", o_voice_index, 0);
    check("reset_done", o_frame_done, 0);
    check("reset_overrun", o_overrun, 0);
    check("reset_ready", o_note_ready, 1);
    check("reset_flag", o_upd_flag, 0);
    check("reset_gate", o_gate, 0);
    check("reset_upd_note", o_upd_note, 0);
    check("reset_upd_voice", o_upd_voice, 0);
    force_tick = 1'b1;
    step();
    step();
    check("t1_first_ps", o_pipeline_state, 0);
    check("t1_first_voice", o_voice_index, 0);
    for (int k = 1; k < 3 * N; k++) begin
      step();
      check("t1_ps", o_pipeline_state, k % 3);
      check("t1_voice", o_voice_index, k / 3);
    end
    step();
    check("t1_done", o_frame_done, 1);
    check("t1_end_ps", o_pipeline_state, 3);
    i_sample_tick = 1'b1;               // tick coincident with frame_done
    step();
    check("t1_coincident_overrun", o_overrun, 1);
    check("t1_coincident_dropped", o_pipeline_state, 3);
    step();
    check("t1_done_cleared", o_frame_done, 0);

    // 2: tick mid-frame is dropped, frame length unchanged, overrun sticky
    do_reset();
    check("t2_overrun_cleared", o_overrun, 0);
    force_tick = 1'b1;
    step();
    n = 0;
    do begin
      if (n == 5) force_tick = 1'b1;
      step();
      n++;
    end while (o_frame_done !== 1'b1 && n < 200);
    check("t2_frame_len", n, 3 * N + 1);
    check("t2_overrun", o_overrun, 1);
    repeat (5) step();
    check("t2_overrun_sticky", o_overrun, 1);
    force_tick = 1'b1;
    step();
    step();
    check("t2_new_frame_starts", o_pipeline_state, 0);
    repeat (3 * N + 2) step();

    // 3: two note-ons; the second waits for an update cycle after the first pulse
    do_reset();
    auto_tick = 1'b0;
    note_req(1'b1, 60);
    check("t3_first_voice", o_upd_voice, 0);
    note_req(1'b1, 64);
    check("t3_second_voice", o_upd_voice, 1);
    check("t3_second_note", o_upd_note, 64);
    check("t3_gate", o_gate, 8'b0000_0011);

    // 4: fill all voices, then steal round-robin
    do_reset();
    auto_tick = 1'b1;
    for (int k = 0; k < N; k++) note_req(1'b1, 60 + k);
    check("t4_full_gate", o_gate, 8'hFF);
    note_req(1'b1, 70);
    check("t4_steal0_voice", o_upd_voice, 0);
    check("t4_steal0_note", o_upd_note, 70);
    note_req(1'b1, 71);
    check("t4_steal1_voice", o_upd_voice, 1);

    // 5: retrigger, release, unmatched release
    do_reset();
    note_req(1'b1, 60);
    note_req(1'b1, 60);
    check("t5_retrig_voice", o_upd_voice, 0);
    check("t5_retrig_gate", o_gate, 8'b0000_0001);
    note_req(1'b0, 60);
    check("t5_off_gate", o_gate, 0);
    note_req(1'b0, 61);
    check("t5_noop_gate", o_gate, 0);
    note_req(1'b1, 62);
    note_req(1'b1, 63);

    // 6: reset in the middle of a search and a frame
    auto_tick = 1'b0;
    force_tick = 1'b1;
    step();
    repeat (4) step();
    i_note_valid = 1'b1;
    i_note_on = 1'b1;
    i_note = 7'd99;
    step();
    i_note_valid = 1'b0;
    step();
    step();
    #2;
    i_reset_n = 1'b0;
    #1;
    check("t6_ps", o_pipeline_state, 3);
    check("t6_voice", o_voice_index, 0);
    check("t6_done", o_frame_done, 0);
    check("t6_overrun", o_overrun, 0);
    check("t6_ready", o_note_ready, 1);
    check("t6_flag", o_upd_flag, 0);
    check("t6_gate", o_gate, 0);
    check("t6_upd_note", o_upd_note, 0);
    check("t6_upd_voice", o_upd_voice, 0);
    model_reset();
    step();
    step();
    i_reset_n = 1'b1;
    for (int k = 0; k < N + 2; k++) begin
      step();
      check("t6_no_pulse", o_upd_flag, 0);
    end
    note_req(1'b1, 50);
    check("t6_fresh_voice", o_upd_voice, 0);

    // 7: randomized note traffic with random sample ticks
    auto_tick = 1'b1;
    for (int r = 0; r < 40; r++) begin
      note_req(($urandom_range(0, 3) != 0), 60 + int'($urandom_range(0, 9)));
      repeat ($urandom_range(0, 3)) step();
    end
    check("rand_final_gate", o_gate, model_gate());

    auto_tick = 1'b0;
    repeat (3 * N + 4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
